nibble_serial_adder: RTL and testbench
======================================

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning operand and sum width in bits; legal values are multiples of 4, minimum 8.
REQ-002 SHALL have port clk, input, 1 bit, meaning the single clock, with all state updating on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit, meaning synchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit, meaning the operand triple is valid.
REQ-005 SHALL have port in_ready, output, 1 bit, meaning the block can accept operands.
REQ-006 SHALL have port a, input, WIDTH bits, meaning operand A.
REQ-007 SHALL have port b, input, WIDTH bits, meaning operand B.
REQ-008 SHALL have port cin, input, 1 bit, meaning carry-in to bit 0.
REQ-009 SHALL have port out_valid, output, 1 bit, meaning the result is valid.
REQ-010 SHALL have port out_ready, input, 1 bit, meaning the consumer accepts the result.
REQ-011 SHALL have port s, output, WIDTH bits, meaning the sum a+b+cin modulo 2^WIDTH.
REQ-012 SHALL have port cout, output, 1 bit, meaning carry-out of bit WIDTH-1.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-014 SHALL drive in_ready=1 only in IDLE, and out_valid=1 only in DONE.
REQ-015 SHALL, in IDLE, capture a, b and cin into internal registers and clear the nibble counter and sum register on in_valid&&in_ready, then go to BUSY.
REQ-016 SHALL, in BUSY, add one 4-bit nibble per cycle, LSB nibble first, with the carry-in of nibble k being the registered cout of nibble k-1 (captured cin for k=0).
REQ-017 SHALL write nibble k sum into s_reg[4k+3:4k] and register its carry-out each BUSY cycle.
REQ-018 SHALL use a nibble counter of width clog2(WIDTH/4), and transition BUSY->DONE on the cycle the last nibble (k=WIDTH/4-1) is processed.
REQ-019 SHALL give a latency, for WIDTH=16, of an accept edge at T and out_valid high after edge T+4, i.e. WIDTH/4 cycles.
REQ-020 SHALL, in DONE, hold s and cout stable until out_valid&&out_ready, then go to IDLE; a new operand can be accepted no earlier than the following cycle.
REQ-021 SHALL ignore in_valid in BUSY and DONE, with no capture and no effect on state.
REQ-022 SHALL drive s and cout from registers only, with no combinational path from inputs to outputs.
REQ-023 SHALL treat the all-ones operand with cin=1 as a legal wrap-around: the sum wraps to 0 and cout=1.
REQ-024 SHALL allow s and cout to hold stale values while out_valid=0; consumers use them only when out_valid=1.

Reset
REQ-025 SHALL, on a clk edge with rst_n=0, go to IDLE and set in_ready=1, out_valid=0, s=0, cout=0, nibble counter=0, and carry register=0.
REQ-026 SHALL treat reset asserted in BUSY or DONE as abandoning the operation, with no out_valid produced for it.
REQ-027 SHALL, on the first edge after rst_n rises, accept in_valid normally.

Structure
REQ-028 SHALL place the state enum (IDLE/BUSY/DONE) and constant NIB_W=4 in shared package nsa_pkg.
REQ-029 SHALL instantiate exactly one combinational sub-module, csa_nibble: a 4-bit carry-select adder slice with inputs a[3:0], b[3:0] and cin, and outputs s[3:0] and cout, built as dual ripple chains for cin=0/1 with output muxing.
REQ-030 SHALL size the sequential RTL at roughly 120-250 lines excluding csa_nibble.

Verification
REQ-031 SHALL cover: a=0x1234, b=0x4321, cin=0 -> out_valid 4 cycles after accept with s=0x5555, cout=0.
REQ-032 SHALL cover: a=0xFFFF, b=0x0001, cin=0 -> s=0x0000, cout=1, with the carry rippling through all four nibbles.
REQ-033 SHALL cover: a=0xFFFF, b=0x0000, cin=1 -> s=0x0000, cout=1; and a=0x8000, b=0x8000, cin=0 -> s=0x0000, cout=1.
REQ-034 SHALL cover: out_ready held 0 for 5 cycles in DONE -> s and cout unchanged, out_valid=1 throughout, in_ready=0; then out_ready=1 -> IDLE next cycle.
REQ-035 SHALL cover: in_valid pulsed with a=0x0F0F during BUSY of a 0x1111+0x2222 add -> result is 0x3333, and the second operand is not captured.
REQ-036 SHALL cover: rst_n=0 for one cycle at BUSY nibble 2 -> next cycle IDLE, out_valid=0, s=0, cout=0, in_ready=1; a fresh 0x0001+0x0001 add then yields 0x0002.

Source files
------------

// File: rtl/nsa_pkg.sv
// Shared types and constants for the nibble-serial adder.
// Holds the controller state encoding and the nibble width.
package nsa_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/csa_nibble.sv
// 4-bit carry-select adder slice: two ripple chains (carry-in 0 and 1) computed
// in parallel, with the real carry-in choosing between them at the output.
module csa_nibble
  import nsa_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] s,
  output logic             cout
);

  for (genvar gi = 0; gi < 2; gi++) begin : g_chain
    logic [NIB_W-1:0] sum;
    logic             carry;

    always_comb begin
      logic c;
      c   = (gi == 1);
      sum = '0;
      for (int i = 0; i < NIB_W; i++) begin
        sum[i] = a[i] ^ b[i] ^ c;
        c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      carry = c;
    end
  end

  assign s    = cin ? g_chain[1].sum   : g_chain[0].sum;
  assign cout = cin ? g_chain[1].carry : g_chain[0].carry;

endmodule

// File: rtl/nibble_serial_adder.sv
// Serial adder that processes one nibble per clock, LSB nibble first, behind a
// valid/ready handshake on both the operand and result sides.
module nibble_serial_adder
  import nsa_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  localparam int NUM_NIB = WIDTH / NIB_W;
  localparam int CNT_W   = $clog2(NUM_NIB);
  localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NUM_NIB - 1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg, s_reg, s_next;
  logic [CNT_W-1:0] cnt_reg;
  logic             carry_reg;
  logic [NIB_W-1:0] a_nib, b_nib, sum_nib;
  logic             carry_nib;

  assign a_nib = a_reg[cnt_reg*NIB_W +: NIB_W];
  assign b_nib = b_reg[cnt_reg*NIB_W +: NIB_W];

  csa_nibble u_csa (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry_reg),
    .s    (sum_nib),
    .cout (carry_nib)
  );

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    s_next     = s_reg;
    s_next[cnt_reg*NIB_W +: NIB_W] = sum_nib;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = BUSY;
      end
      BUSY: begin
        if (cnt_reg == LAST_NIB) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // carry_reg doubles as the result carry-out once the last nibble is done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      s_reg     <= '0;
      cnt_reg   <= '0;
      carry_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= a;
            b_reg     <= b;
            carry_reg <= cin;
            cnt_reg   <= '0;
            s_reg     <= '0;
          end
        end
        BUSY: begin
          s_reg     <= s_next;
          carry_reg <= carry_nib;
          cnt_reg   <= cnt_reg + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign s    = s_reg;
  assign cout = carry_reg;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder: expected sums are queued on accept
// and compared on the output handshake.
module tb_nibble_serial_adder;

  localparam int W       = 16;
  localparam int LAT     = W / 4;
  localparam int LAT_MAX = 20;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] s;
  logic         cout;

  logic [W:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_add(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci,
                        input int hold, input bit poke, input bit skip_wait, input string tag);
    logic [W:0] e;
    int cyc;
    if (!skip_wait) @(negedge clk);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    a = av; b = bv; cin = ci; in_valid = 1'b1;
    exp_q.push_back({1'b0, av} + {1'b0, bv} + (W+1)'(ci));
    @(negedge clk);
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    check({tag, "_busy_ready"}, 32'(in_ready), 32'd0);
    cyc = 0;
    while (!out_valid && cyc < LAT_MAX) begin
      if (poke && cyc == 1) begin in_valid = 1'b1; a = 16'h0F0F; end
      else in_valid = 1'b0;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    check({tag, "_latency"}, 32'(cyc), 32'(LAT));
    for (int i = 0; i < hold; i++) begin
      if (poke) begin in_valid = 1'b1; a = 16'h0F0F; end
      check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
      check({tag, "_hold_s"}, 32'(s), 32'(exp_q[0][W-1:0]));
      check({tag, "_hold_cout"}, 32'(cout), 32'(exp_q[0][W]));
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    if (out_valid && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      $display("[TB] %s a=0x%04h b=0x%04h cin=%0d -> s=0x%04h cout=%0d (exp 0x%04h/%0d)",
               tag, av, bv, ci, s, cout, e[W-1:0], e[W]);
      check({tag, "_s"}, 32'(s), 32'(e[W-1:0]));
      check({tag, "_cout"}, 32'(cout), 32'(e[W]));
    end else begin
      check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    end
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
    if (poke) begin
      repeat (3) begin
        @(negedge clk);
        check({tag, "_no_capture"}, 32'(out_valid), 32'd0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_s", 32'(s), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    rst_n = 1'b1;
    do_add(16'h1234, 16'h4321, 1'b0, 0, 1'b0, 1'b1, "basic");
    do_add(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0, 1'b0, "ripple");
    do_add(16'hFFFF, 16'h0000, 1'b1, 0, 1'b0, 1'b0, "wrap_cin");
    do_add(16'h8000, 16'h8000, 1'b0, 0, 1'b0, 1'b0, "msb_carry");
    do_add(16'hABCD, 16'h1234, 1'b0, 5, 1'b0, 1'b0, "backpressure");
    do_add(16'h1111, 16'h2222, 1'b0, 2, 1'b1, 1'b0, "ignore_in_valid");

    // abandon an add with a one-cycle reset while nibble 2 is being processed
    @(negedge clk);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
    exp_q.push_back({1'b0, a} + {1'b0, b});
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    void'(exp_q.pop_back());
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready2", 32'(in_ready), 32'd1);
    check("abort_s", 32'(s), 32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    rst_n = 1'b1;
    do_add(16'h0001, 16'h0001, 1'b0, 0, 1'b0, 1'b1, "post_reset");

    for (int i = 0; i < 6; i++)
      do_add(W'($urandom), W'($urandom), 1'($urandom), $urandom_range(0, 2), 1'b0, 1'b0, "random");

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
